// File: rtl/data_block_generator_pkg.sv
// Shared encodings and PRBS11 constants for the PCS test-data block generator.
package pcs_datagen_pkg;

   typedef enum logic [1:0] {
      MODE_PRBS  = 2'd0,
      MODE_CNT   = 2'd1,
      MODE_FIXED = 2'd2,
      MODE_WALK  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int PRBS_LEN   = 11;
   localparam int PRBS_TAP_A = 10;
   localparam int PRBS_TAP_B = 8;
   localparam logic [PRBS_LEN-1:0] PRBS_SEED_STEP = 11'h0A5;

   // All-zero is the LFSR lock-up state, so it is replaced by 1.
   function automatic logic [PRBS_LEN-1:0] lane_seed(input logic [PRBS_LEN-1:0] base,
                                                      input int lane);
      logic [PRBS_LEN-1:0] seed;
      seed = base ^ PRBS_LEN'(lane * int'(PRBS_SEED_STEP));
      if (seed == '0) seed = PRBS_LEN'(1);
      return seed;
   endfunction

endpackage

// File: rtl/data_block_generator_if.sv
// Block stream handshake between the data block generator and its consumer.
interface data_block_generator_if #(
   parameter int NB_DATA = 64
);
   logic [NB_DATA-1:0] o_data_block;
   logic               o_valid;
   logic               o_err_injected;
   logic               i_ready;

   modport master (output o_data_block, o_valid, o_err_injected, input i_ready);
   modport slave  (input o_data_block, o_valid, o_err_injected, output i_ready);
endinterface

// File: rtl/data_block_generator_prbs11_lane.sv
// One PRBS11 lane (x^11+x^9+1, Fibonacci) emitting NB_BYTE bits per block, earliest bit in the MSB.
module prbs11_lane
   import pcs_datagen_pkg::*;
#(
   parameter int                  NB_BYTE = 8,
   parameter logic [PRBS_LEN-1:0] SEED    = 11'h7FF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic               i_advance,
   output logic [NB_BYTE-1:0] o_bits
);

   logic [PRBS_LEN-1:0] state_q;
   logic [PRBS_LEN-1:0] state_d;
   logic [PRBS_LEN-1:0] walk;

   // On load the bits come straight from the seed so a new burst starts seed-aligned.
   always_comb begin
      walk   = i_load ? SEED : state_q;
      o_bits = '0;
      for (int i = 0; i < NB_BYTE; i++) begin
         o_bits = (o_bits << 1) | NB_BYTE'(walk[PRBS_LEN-1]);
         walk   = {walk[PRBS_LEN-2:0], walk[PRBS_TAP_A] ^ walk[PRBS_TAP_B]};
      end
      state_d = (i_load || i_advance) ? walk : state_q;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) state_q <= SEED;
      else         state_q <= state_d;
   end

endmodule

// File: rtl/data_block_generator.sv
// Multi-lane test-data source: PRBS11 / counter / fixed / walking-one blocks over valid/ready,
// with programmable bursts and single-shot LSB error injection.
module data_block_generator
   import pcs_datagen_pkg::*;
#(
   parameter int                  NB_BYTE   = 8,
   parameter int                  N_LANES   = 8,
   parameter int                  NB_COUNT  = 32,
   parameter logic [PRBS_LEN-1:0] PRBS_SEED = 11'h7FF
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_enable,
   input  logic                       i_start,
   input  logic                       i_stop,
   input  logic [1:0]                 i_mode,
   input  logic [NB_BYTE*N_LANES-1:0] i_pattern,
   input  logic [NB_COUNT-1:0]        i_burst_len,
   input  logic                       i_inject_error,
   data_block_generator_if.master     bus,
   output logic [NB_COUNT-1:0]        o_block_count,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int                 NB_DATA  = NB_BYTE * N_LANES;
   localparam int                 NB_POS   = $clog2(NB_DATA);
   localparam logic [NB_POS-1:0]  POS_LAST = NB_POS'(NB_DATA - 1);
   localparam logic [NB_DATA-1:0] WALK_MSB = {1'b1, {(NB_DATA-1){1'b0}}};

   state_e               state_q, state_d;
   mode_e                mode_q, mode_d;
   logic [NB_COUNT-1:0]  burst_q, burst_d;
   logic [NB_COUNT-1:0]  count_q, count_d;
   logic [NB_POS-1:0]    pos_q, pos_d;
   logic                 stop_q, stop_d;
   logic                 armed_q, armed_d;
   logic [NB_DATA-1:0]   data_q, data_d;

   logic                 valid;
   logic                 transfer;
   logic                 lane_load;
   logic                 lane_advance;
   logic                 gen_block;
   logic [NB_DATA-1:0]   prbs_block;
   logic [NB_DATA-1:0]   next_block;

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      prbs11_lane #(
         .NB_BYTE (NB_BYTE),
         .SEED    (lane_seed(PRBS_SEED, k))
      ) u_lane (
         .i_clock   (i_clock),
         .i_reset   (i_reset),
         .i_load    (lane_load),
         .i_advance (lane_advance),
         .o_bits    (prbs_block[NB_DATA-1-k*NB_BYTE -: NB_BYTE])
      );
   end

   assign valid    = (state_q == ST_RUN);
   assign transfer = valid & bus.i_ready & i_enable;

   // A stop seen before acceptance is remembered so o_valid never drops early.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      burst_d      = burst_q;
      count_d      = count_q;
      pos_d        = pos_q;
      stop_d       = stop_q;
      armed_d      = armed_q;
      lane_load    = 1'b0;
      lane_advance = 1'b0;
      gen_block    = 1'b0;
      if (i_enable) begin
         armed_d = armed_q ? ~transfer : i_inject_error;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  state_d   = ST_RUN;
                  mode_d    = mode_e'(i_mode);
                  burst_d   = i_burst_len;
                  count_d   = '0;
                  pos_d     = '0;
                  stop_d    = 1'b0;
                  lane_load = 1'b1;
                  gen_block = 1'b1;
               end
            end
            ST_RUN: begin
               if (i_stop) stop_d = 1'b1;
               if (transfer) begin
                  count_d      = count_q + NB_COUNT'(1);
                  pos_d        = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                  lane_advance = 1'b1;
                  gen_block    = 1'b1;
                  stop_d       = 1'b0;
                  if (stop_q || i_stop || (burst_q != '0 && count_d == burst_q))
                     state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      case (mode_d)
         MODE_PRBS:  next_block = prbs_block;
         MODE_CNT:   next_block = NB_DATA'(count_d);
         MODE_FIXED: next_block = i_pattern;
         MODE_WALK:  next_block = WALK_MSB >> pos_d;
         default:    next_block = prbs_block;
      endcase
      data_d = gen_block ? next_block : data_q;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_PRBS;
         burst_q <= '0;
         count_q <= '0;
         pos_q   <= '0;
         stop_q  <= 1'b0;
         armed_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         burst_q <= burst_d;
         count_q <= count_d;
         pos_q   <= pos_d;
         stop_q  <= stop_d;
         armed_q <= armed_d;
         data_q  <= data_d;
      end
   end

   // The error bit is overlaid on the presented block only, leaving the generators untouched.
   assign bus.o_valid        = valid;
   assign bus.o_data_block   = data_q ^ NB_DATA'(armed_q & valid);
   assign bus.o_err_injected = transfer & armed_q;
   assign o_block_count      = count_q;
   assign o_busy             = (state_q != ST_IDLE);
   assign o_done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_data_block_generator.sv
// Randomized scoreboard bench for data_block_generator: a driver pushes expected blocks from a
// spec-level reference model, and a monitor pops and compares on every observed transfer.
module tb_data_block_generator;

   localparam int NB_BYTE = 8;
   localparam int N_LANES = 8;
   localparam int NB_DATA = 64;
   localparam int PERIOD  = 2047;

   typedef struct packed {
      logic [NB_DATA-1:0] data;
      logic               err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic        start;
   logic        stop;
   logic [1:0]  mode;
   logic [63:0] pattern;
   logic [31:0] burst_len;
   logic        inject;
   logic [31:0] block_count;
   logic        busy;
   logic        done;

   data_block_generator_if #(.NB_DATA(NB_DATA)) bus ();

   data_block_generator #(
      .NB_BYTE   (NB_BYTE),
      .N_LANES   (N_LANES),
      .NB_COUNT  (32),
      .PRBS_SEED (11'h7FF)
   ) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_enable       (en),
      .i_start        (start),
      .i_stop         (stop),
      .i_mode         (mode),
      .i_pattern      (pattern),
      .i_burst_len    (burst_len),
      .i_inject_error (inject),
      .bus            (bus),
      .o_block_count  (block_count),
      .o_busy         (busy),
      .o_done         (done)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   bit          prbs_seq [N_LANES][PERIOD];
   int          m_idx;
   int          m_mode;
   int          m_len;
   bit          m_running;
   bit          m_done;
   bit          m_armed;
   bit          m_stop_pend;
   logic [63:0] m_pat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Each lane's bit stream is precomputed once; block n of lane k is bits n*8.. of that stream.
   task automatic buildPrbs();
      for (int k = 0; k < N_LANES; k++) begin
         int s;
         s = (11'h7FF ^ ((k * 'hA5) & 'h7FF)) & 'h7FF;
         if (s == 0) s = 1;
         for (int t = 0; t < PERIOD; t++) begin
            int fb;
            prbs_seq[k][t] = bit'((s >> 10) & 1);
            fb = ((s >> 10) ^ (s >> 8)) & 1;
            s  = ((s << 1) | fb) & 'h7FF;
         end
      end
   endtask

   function automatic logic [63:0] modelBlock(input int n);
      logic [63:0] b;
      b = '0;
      case (m_mode)
         0: begin
            for (int k = 0; k < N_LANES; k++)
               for (int i = 0; i < NB_BYTE; i++)
                  b[63 - (k * NB_BYTE + i)] = prbs_seq[k][(n * NB_BYTE + i) % PERIOD];
         end
         1:       b = 64'(n);
         2:       b = m_pat;
         default: b = 64'h8000_0000_0000_0000 >> (n % NB_DATA);
      endcase
      return b;
   endfunction

   // One clock of stimulus, entered and left at posedge+1.
   task automatic applyStimulus(input bit rdy, input bit en_i, input bit stop_i, input bit inj_i);
      bit          xfer;
      bit          ended;
      logic [63:0] cur;
      logic [63:0] pat_now;
      pat_now     = {$urandom, $urandom};
      pattern     = pat_now;
      bus.i_ready = rdy;
      en          = en_i;
      stop        = stop_i;
      inject      = inj_i;
      xfer        = m_running && rdy && en_i;
      checkOutput("valid", 64'(bus.o_valid), 64'(m_running));
      checkOutput("busy", 64'(busy), 64'(m_running || m_done));
      checkOutput("done", 64'(done), 64'(m_done));
      checkOutput("count", 64'(block_count), 64'(m_idx));
      if (m_running) begin
         cur = modelBlock(m_idx) ^ 64'(m_armed);
         if (xfer) sb_q.push_back('{cur, m_armed});
         else      checkOutput("held_data", bus.o_data_block, cur);
      end
      @(posedge clk);
      #1;
      stop   = 1'b0;
      inject = 1'b0;
      if (en_i) begin
         ended = 1'b0;
         if (xfer) begin
            m_idx++;
            m_pat = pat_now;
            if ((m_len != 0 && m_idx == m_len) || m_stop_pend || stop_i) ended = 1'b1;
            m_stop_pend = 1'b0;
         end else if (m_running && stop_i) begin
            m_stop_pend = 1'b1;
         end
         m_armed = m_armed ? !xfer : inj_i;
         m_done  = ended;
         if (ended) m_running = 1'b0;
      end
   endtask

   task automatic startBurst(input int md, input int len, input logic [63:0] pat, input bit with_stop);
      checkOutput("start_idle_busy", 64'(busy), 64'd0);
      start       = 1'b1;
      stop        = with_stop;
      mode        = 2'(md);
      burst_len   = 32'(len);
      pattern     = pat;
      bus.i_ready = 1'b0;
      en          = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      stop        = 1'b0;
      m_running   = 1'b1;
      m_done      = 1'b0;
      m_idx       = 0;
      m_mode      = md;
      m_len       = len;
      m_pat       = pat;
      m_stop_pend = 1'b0;
   endtask

   task automatic doReset();
      rst         = 1'b1;
      bus.i_ready = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      inject      = 1'b0;
      en          = 1'b1;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      m_running   = 1'b0;
      m_done      = 1'b0;
      m_idx       = 0;
      m_armed     = 1'b0;
      m_stop_pend = 1'b0;
      checkOutput("rst_valid", 64'(bus.o_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_count", 64'(block_count), 64'd0);
      checkOutput("rst_data", bus.o_data_block, 64'd0);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: compares every accepted block against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (en && bus.o_valid && bus.i_ready) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_empty: got transfer of %h expected none (t=%0t)",
                        bus.o_data_block, $time);
            end else begin
               e = sb_q.pop_front();
               checkOutput("xfer_data", bus.o_data_block, e.data);
               checkOutput("xfer_err", 64'(bus.o_err_injected), 64'(e.err));
            end
         end else begin
            checkOutput("idle_err", 64'(bus.o_err_injected), 64'd0);
         end
      end
   end

   initial begin
      int guard;
      int len;
      rst         = 1'b1;
      en          = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      mode        = 2'd0;
      pattern     = '0;
      burst_len   = '0;
      inject      = 1'b0;
      bus.i_ready = 1'b0;
      buildPrbs();
      @(posedge clk);
      doReset();
      idleCycles(1);

      $display("[TB] counter burst of 4, start+stop together");
      startBurst(1, 4, 64'd0, 1'b1);
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] backpressure 1,0,0,1");
      startBurst(1, 4, 64'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] random counter bursts with enable gaps and injections");
      for (int b = 0; b < 4; b++) begin
         len = $urandom_range(1, 12);
         startBurst(1, len, 64'd0, 1'b0);
         guard = 0;
         while (m_running && guard < 300) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, 1'b0,
                          $urandom_range(0, 7) == 0);
            guard++;
         end
         checkOutput("burst_finished", 64'(m_running), 64'd0);
         idleCycles(2);
      end

      $display("[TB] fixed pattern, continuous, then stop");
      startBurst(2, 0, {$urandom, $urandom}, 1'b0);
      repeat (20) applyStimulus($urandom_range(0, 1) != 0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] PRBS continuous, 2048 blocks");
      startBurst(0, 0, 64'd0, 1'b0);
      guard = 0;
      while (m_idx < PERIOD && guard < 6000) begin
         applyStimulus($urandom_range(0, 3) != 0, 1'b1, 1'b0, 1'b0);
         guard++;
      end
      checkOutput("prbs_reached", 64'(m_idx), 64'(PERIOD));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      idleCycles(2);
      startBurst(0, 1, 64'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] walking one, 65 transfers");
      startBurst(3, 65, 64'd0, 1'b0);
      repeat (65) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] error injection during stall, then stop");
      startBurst(1, 0, 64'd0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] error armed in idle hits first block of next burst");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      startBurst(1, 2, 64'd0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(2);

      $display("[TB] reset mid-burst, then seed-identical restart");
      startBurst(0, 10, 64'd0, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      doReset();
      idleCycles(2);
      startBurst(0, 3, 64'd0, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(3);

      checkOutput("sb_leftover", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
